// File: rtl/drum_audio_tx_if.sv
// Handshake bundle between the drum solver/codec and drum_audio_tx:
// step_go/step_done pacing on the solver side, valid/ready sample stream on the codec side.
interface drum_audio_tx_if #(
    parameter int SAMPLE_W = 18,
    parameter int AUDIO_W  = 32
);
    logic                step_go;
    logic                step_done;
    logic [SAMPLE_W-1:0] center_amp;
    logic [AUDIO_W-1:0]  audio_data;
    logic                audio_valid;
    logic                audio_ready;

    modport master (
        output step_go,
        input  step_done,
        input  center_amp,
        output audio_data,
        output audio_valid,
        input  audio_ready
    );

    modport slave (
        input  step_go,
        output step_done,
        output center_amp,
        input  audio_data,
        input  audio_valid,
        output audio_ready
    );
endinterface

// File: rtl/drum_audio_tx.sv
// Paces the drum solver one timestep at a time and turns the center amplitude into codec samples.
// Optional DC blocker in the capture path: define DRUM_AUDIO_TX_DC_BLOCK_EN.
module drum_audio_tx #(
    parameter int FIFO_DEPTH = 8,
    parameter int SAMPLE_W   = 18,
    parameter int AUDIO_W    = 32,
    parameter int GAIN_SHIFT = 14
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_enable,
    drum_audio_tx_if.master               io_bus,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
    output logic [15:0]                   o_drop_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int WW = AUDIO_W + GAIN_SHIFT;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_REQ     = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_PUSH    = 3'd3;
`ifdef DRUM_AUDIO_TX_DC_BLOCK_EN
    localparam logic [2:0] S_SCALE   = 3'd4;
`endif

    localparam logic [AUDIO_W-1:0] SAT_MIN = {1'b1, {(AUDIO_W-1){1'b0}}};
    localparam logic [AUDIO_W-1:0] SAT_MAX = ~SAT_MIN;

    logic [2:0]                 r_state;
    logic                       r_step_go;
    logic signed [SAMPLE_W-1:0] r_cap;
    logic [AUDIO_W-1:0]         r_scaled;
    logic [15:0]                r_drop;

    logic [AUDIO_W-1:0]         r_mem [FIFO_DEPTH];
    logic [AW-1:0]              r_wr;
    logic [AW-1:0]              r_rd;
    logic [AW:0]                r_count;
    logic [AUDIO_W-1:0]         r_data;

    logic                       w_full;
    logic                       w_valid;
    logic                       w_push;
    logic                       w_pop;
    logic [AW:0]                w_count_nxt;
    logic [AW-1:0]              w_rd_nxt;

    logic signed [SAMPLE_W-1:0] w_src;
    logic signed [WW-1:0]       w_wide;
    logic [WW-AUDIO_W:0]        w_top;
    logic [AUDIO_W-1:0]         w_sat;

`ifdef DRUM_AUDIO_TX_DC_BLOCK_EN
    localparam int DW = SAMPLE_W + 2;
    localparam logic [SAMPLE_W-1:0] DC_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};
    localparam logic [SAMPLE_W-1:0] DC_MAX = ~DC_MIN;

    logic signed [SAMPLE_W-1:0] r_x_prev;
    logic signed [SAMPLE_W-1:0] r_y_prev;
    logic signed [SAMPLE_W-1:0] r_dc_y;
    logic signed [DW-1:0]       w_dc_sum;
    logic [DW-SAMPLE_W:0]       w_dc_top;
    logic [SAMPLE_W-1:0]        w_dc_sat;

    // y = x - x_prev + y_prev - y_prev/256, wide enough that only the final narrowing can overflow
    assign w_dc_sum = DW'(r_cap) - DW'(r_x_prev) + DW'(r_y_prev) - (DW'(r_y_prev) >>> 8);
    assign w_dc_top = w_dc_sum[DW-1:SAMPLE_W-1];
    assign w_dc_sat = (&w_dc_top || ~|w_dc_top) ? w_dc_sum[SAMPLE_W-1:0]
                    : (w_dc_sum[DW-1] ? DC_MIN : DC_MAX);
    assign w_src    = r_dc_y;
`else
    assign w_src    = r_cap;
`endif

    // Signed size cast sign-extends before the shift; saturate if the upper bits disagree.
    assign w_wide = WW'(w_src) <<< GAIN_SHIFT;
    assign w_top  = w_wide[WW-1:AUDIO_W-1];
    assign w_sat  = (&w_top || ~|w_top) ? w_wide[AUDIO_W-1:0]
                  : (w_wide[WW-1] ? SAT_MIN : SAT_MAX);

    assign w_full  = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_valid = (r_count != '0);
    assign w_push  = (r_state == S_PUSH);
    assign w_pop   = w_valid & io_bus.audio_ready;

    always_comb begin
        w_count_nxt = r_count;
        w_rd_nxt    = w_pop ? r_rd + 1'b1 : r_rd;
        if (w_push && !w_pop)
            w_count_nxt = r_count + 1'b1;
        else if (!w_push && w_pop)
            w_count_nxt = r_count - 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_step_go <= 1'b0;
            r_cap     <= '0;
            r_scaled  <= '0;
`ifdef DRUM_AUDIO_TX_DC_BLOCK_EN
            r_x_prev  <= '0;
            r_y_prev  <= '0;
            r_dc_y    <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_enable && !w_full) begin
                        r_state   <= S_REQ;
                        r_step_go <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (io_bus.step_done) begin
                        r_cap     <= io_bus.center_amp;
                        r_step_go <= 1'b0;
                        r_state   <= S_CAPTURE;
                    end
                end
`ifdef DRUM_AUDIO_TX_DC_BLOCK_EN
                S_CAPTURE: begin
                    r_dc_y   <= w_dc_sat;
                    r_x_prev <= r_cap;
                    r_y_prev <= w_dc_sat;
                    r_state  <= S_SCALE;
                end
                S_SCALE: begin
                    r_scaled <= w_sat;
                    r_state  <= S_PUSH;
                end
`else
                S_CAPTURE: begin
                    r_scaled <= w_sat;
                    r_state  <= S_PUSH;
                end
`endif
                S_PUSH:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A step_done outside REQ is a protocol violation: count it, leave the FSM alone.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_drop <= '0;
        else if (io_bus.step_done && (r_state != S_REQ) && (r_drop != 16'hFFFF))
            r_drop <= r_drop + 16'd1;
    end

    always_ff @(posedge i_clk) begin
        if (w_push)
            r_mem[r_wr] <= r_scaled;
    end

    // audio_data tracks the head; a sample pushed into the head slot bypasses the memory.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_data  <= '0;
        end else begin
            if (w_push)
                r_wr <= r_wr + 1'b1;
            r_rd    <= w_rd_nxt;
            r_count <= w_count_nxt;
            if (w_count_nxt != '0)
                r_data <= (w_push && (w_rd_nxt == r_wr)) ? r_scaled : r_mem[w_rd_nxt];
        end
    end

    assign io_bus.step_go     = r_step_go;
    assign io_bus.audio_valid = w_valid;
    assign io_bus.audio_data  = r_data;
    assign o_fifo_count       = r_count;
    assign o_drop_count       = r_drop;
endmodule

// File: tb/tb_drum_audio_tx.sv
// Directed bench for drum_audio_tx: u0 at default gain, u1 at GAIN_SHIFT=20 for saturation.
module tb_drum_audio_tx;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en0 = 1'b0;
  logic        en1 = 1'b0;
  logic [3:0]  cnt0, cnt1;
  logic [15:0] drop0, drop1;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  drum_audio_tx_if #(.SAMPLE_W(18), .AUDIO_W(32)) b0 ();
  drum_audio_tx_if #(.SAMPLE_W(18), .AUDIO_W(32)) b1 ();

  drum_audio_tx #(.FIFO_DEPTH(8), .SAMPLE_W(18), .AUDIO_W(32), .GAIN_SHIFT(14)) u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en0), .io_bus(b0),
    .o_fifo_count(cnt0), .o_drop_count(drop0));

  drum_audio_tx #(.FIFO_DEPTH(8), .SAMPLE_W(18), .AUDIO_W(32), .GAIN_SHIFT(20)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en1), .io_bus(b1),
    .o_fifo_count(cnt1), .o_drop_count(drop1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_go(input int sel, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (((sel == 0) ? b0.step_go : b1.step_go) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL wait_go%0d: step_go=0 after 50 cycles, want 1", sel);
    end
  endtask

  task automatic do_step(input int sel, input logic [17:0] amp);
    bit ok;
    wait_go(sel, ok);
    if (sel == 0) begin b0.center_amp = amp; b0.step_done = 1'b1; end
    else          begin b1.center_amp = amp; b1.step_done = 1'b1; end
    tick();
    b0.step_done = 1'b0;
    b1.step_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en0 = 1'b0; en1 = 1'b0;
    repeat (10) tick();
    total++; if (b0.step_go !== 1'b0) begin bad++; $display("FAIL reset_step_go: got %b want 0", b0.step_go); end
    total++; if (b0.audio_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", b0.audio_valid); end
    total++; if (cnt0 !== 4'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", cnt0); end
    total++; if (drop0 !== 16'd0) begin bad++; $display("FAIL reset_drop: got %0d want 0", drop0); end
    total++; if (b0.audio_data !== 32'd0) begin bad++; $display("FAIL reset_data: got %h want 0", b0.audio_data); end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    b0.audio_ready = 1'b0;
    en0 = 1'b1;
    do_step(0, 18'h00800);
    en0 = 1'b0;
    total++; if (b0.audio_valid !== 1'b0) begin bad++; $display("FAIL single_valid_n1: got %b want 0", b0.audio_valid); end
    tick();
    total++; if (b0.audio_valid !== 1'b0) begin bad++; $display("FAIL single_valid_n2: got %b want 0", b0.audio_valid); end
    tick();
    total++; if (b0.audio_valid !== 1'b1) begin bad++; $display("FAIL single_valid_n3: got %b want 1", b0.audio_valid); end
    total++; if (b0.audio_data !== 32'h02000000) begin bad++; $display("FAIL single_data: got %h want 02000000", b0.audio_data); end
    total++; if (cnt0 !== 4'd1) begin bad++; $display("FAIL single_count: got %0d want 1", cnt0); end
    b0.audio_ready = 1'b1;
    tick();
    b0.audio_ready = 1'b0;
    total++; if (cnt0 !== 4'd0) begin bad++; $display("FAIL single_pop_count: got %0d want 0", cnt0); end
    total++; if (b0.audio_data !== 32'h02000000) begin bad++; $display("FAIL single_hold_data: got %h want 02000000", b0.audio_data); end
    total++; if (b0.step_go !== 1'b0) begin bad++; $display("FAIL single_no_req: got %b want 0", b0.step_go); end
  endtask

  task automatic test_saturation();
    b1.audio_ready = 1'b0;
    en1 = 1'b1;
    do_step(1, 18'h1FFFF);
    tick(); tick();
    total++; if (b1.audio_data !== 32'h7FFFFFFF) begin bad++; $display("FAIL sat_pos: got %h want 7fffffff", b1.audio_data); end
    b1.audio_ready = 1'b1;
    tick();
    b1.audio_ready = 1'b0;
    do_step(1, 18'h20000);
    en1 = 1'b0;
    tick(); tick();
    total++; if (b1.audio_data !== 32'h80000000) begin bad++; $display("FAIL sat_neg: got %h want 80000000", b1.audio_data); end
    total++; if (cnt1 !== 4'd1) begin bad++; $display("FAIL sat_count: got %0d want 1", cnt1); end
  endtask

  task automatic test_backpressure();
    bit go_seen;
    logic [31:0] exp;
    b0.audio_ready = 1'b0;
    en0 = 1'b1;
    for (int i = 0; i < 8; i++) do_step(0, 18'((i + 1) * 64));
    go_seen = 1'b0;
    repeat (10) begin tick(); go_seen |= b0.step_go; end
    total++; if (go_seen !== 1'b0) begin bad++; $display("FAIL bp_step_go: got %b want 0", go_seen); end
    total++; if (cnt0 !== 4'd8) begin bad++; $display("FAIL bp_full_count: got %0d want 8", cnt0); end
    total++; if (drop0 !== 16'd0) begin bad++; $display("FAIL bp_drop: got %0d want 0", drop0); end
    total++; if (b0.audio_data !== 32'h00100000) begin bad++; $display("FAIL bp_head: got %h want 00100000", b0.audio_data); end
    b0.audio_ready = 1'b1;
    tick();
    b0.audio_ready = 1'b0;
    total++; if (cnt0 !== 4'd7) begin bad++; $display("FAIL bp_after_pop: got %0d want 7", cnt0); end
    total++; if (b0.audio_data !== 32'h00200000) begin bad++; $display("FAIL bp_head2: got %h want 00200000", b0.audio_data); end
    do_step(0, 18'(9 * 64));
    en0 = 1'b0;
    tick(); tick();
    total++; if (cnt0 !== 4'd8) begin bad++; $display("FAIL bp_refill: got %0d want 8", cnt0); end
    for (int k = 0; k < 8; k++) begin
      exp = 32'(k + 2) << 20;
      total++; if (b0.audio_data !== exp) begin bad++; $display("FAIL bp_drain%0d: got %h want %h", k, b0.audio_data, exp); end
      b0.audio_ready = 1'b1;
      tick();
    end
    b0.audio_ready = 1'b0;
    total++; if (cnt0 !== 4'd0) begin bad++; $display("FAIL bp_empty: got %0d want 0", cnt0); end
  endtask

  task automatic test_violation();
    bit ok;
    en0 = 1'b0;
    b0.step_done = 1'b1;
    tick();
    b0.step_done = 1'b0;
    total++; if (drop0 !== 16'd1) begin bad++; $display("FAIL viol_drop: got %0d want 1", drop0); end
    total++; if (cnt0 !== 4'd0) begin bad++; $display("FAIL viol_count: got %0d want 0", cnt0); end
    total++; if (b0.step_go !== 1'b0) begin bad++; $display("FAIL viol_fsm: got %b want 0", b0.step_go); end
    b0.audio_ready = 1'b0;
    en0 = 1'b1;
    do_step(0, 18'h00100);
    wait_go(0, ok);
    total++; if (cnt0 !== 4'd1) begin bad++; $display("FAIL viol_pre_rst_count: got %0d want 1", cnt0); end
    rst_n = 1'b0;
    #1;
    total++; if (b0.step_go !== 1'b0) begin bad++; $display("FAIL rst_step_go: got %b want 0", b0.step_go); end
    total++; if (cnt0 !== 4'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", cnt0); end
    total++; if (b0.audio_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", b0.audio_valid); end
    total++; if (drop0 !== 16'd0) begin bad++; $display("FAIL rst_drop: got %0d want 0", drop0); end
    en0 = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_streaming();
    logic [31:0] exp_q[$];
    int got = 0;
    int maxc = 0;
    en0 = 1'b1;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          int v;
          v = i * 261 - 130000;
          exp_q.push_back(32'(v * 16384));
          do_step(0, 18'(v));
        end
        en0 = 1'b0;
      end
      begin
        int cyc = 0;
        while (got < 1000 && cyc < 30000) begin
          b0.audio_ready = ($urandom_range(0, 1) == 1);
          if (int'(cnt0) > maxc) maxc = int'(cnt0);
          if (b0.audio_valid && b0.audio_ready) begin
            total++;
            if (exp_q.size() == 0) begin
              bad++; $display("FAIL stream_extra%0d: got %h want none", got, b0.audio_data);
            end else begin
              if (b0.audio_data !== exp_q[0]) begin
                bad++; $display("FAIL stream%0d: got %h want %h", got, b0.audio_data, exp_q[0]);
              end
              void'(exp_q.pop_front());
            end
            got++;
          end
          tick();
          cyc++;
        end
        b0.audio_ready = 1'b0;
      end
    join
    total++; if (got != 1000) begin bad++; $display("FAIL stream_got: got %0d want 1000", got); end
    total++; if (maxc > 8) begin bad++; $display("FAIL stream_max_count: got %0d want <=8", maxc); end
    total++; if (drop0 !== 16'd0) begin bad++; $display("FAIL stream_drop: got %0d want 0", drop0); end
    total++; if (cnt0 !== 4'd0) begin bad++; $display("FAIL stream_left: got %0d want 0", cnt0); end
  endtask

  initial begin
    b0.step_done = 1'b0; b0.center_amp = '0; b0.audio_ready = 1'b0;
    b1.step_done = 1'b0; b1.center_amp = '0; b1.audio_ready = 1'b0;
    test_reset();
    test_single();
    test_saturation();
    test_backpressure();
    test_violation();
    test_streaming();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
